// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared sizes and types for the UART 16550 data FIFO.
//   FIFO_WIDTH / FIFO_DEPTH / FIFO_AW : default word width, entry count, pointer width
//   fifo_data_t : one FIFO word
//   fifo_cnt_t  : fill count (one bit wider than a pointer so 16 is representable)
package uart_fifo_pkg;
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;

  typedef logic [FIFO_WIDTH-1:0] fifo_data_t;
  typedef logic [FIFO_AW:0]      fifo_cnt_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous (combinational) read port. Contents are not reset.
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: 16 x 8 show-ahead FIFO for the UART 16550 TX/RX paths.
// Build option: define FIFO_STICKY_ERR_EN to make overrun/underrun sticky
// until reset; otherwise they are one-cycle pulses.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   en           : global enable; 0 ignores push/pop and freezes state
//   push_in/din  : write request / data
//   pop_in       : read request
//   dout         : head entry (0 when empty)
//   empty / full : decoded from the fill count
//   overrun      : push rejected because full (registered)
//   underrun     : pop attempted while empty (registered)
//   threshold    : fill-level trigger, 0 disables
//   thre_trigger : count >= threshold (threshold != 0)
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter  int WIDTH = FIFO_WIDTH,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overrun,
  output logic             underrun,
  input  logic [AW-1:0]    threshold,
  output logic             thre_trigger
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic             push_ok, pop_ok;
  logic             ovr_hit, udr_hit;
  logic [WIDTH-1:0] mem_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // When full, a simultaneous pop frees the slot the push lands in.
  assign push_ok = en & push_in & (~full | pop_in);
  assign pop_ok  = en & pop_in & ~empty;
  assign ovr_hit = en & push_in & full & ~pop_in;
  assign udr_hit = en & pop_in & empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
`ifdef FIFO_STICKY_ERR_EN
    overrun_d  = overrun_q | ovr_hit;
    underrun_d = underrun_q | udr_hit;
`else
    // en=0 makes both hits 0, so the pulses clear while disabled.
    overrun_d  = ovr_hit;
    underrun_d = udr_hit;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  uart_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Memory is not reset, so mask the stale head while empty.
  assign dout         = empty ? '0 : mem_rdata;
  assign overrun      = overrun_q;
  assign underrun     = underrun_q;
  assign thre_trigger = (threshold != '0) & (count_q >= {1'b0, threshold});

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       en, push_in, pop_in;
  logic [7:0] din, dout;
  logic       empty, full, overrun, underrun, thre_trigger;
  logic [3:0] threshold;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain byte queue plus expected error flags.
  byte unsigned q[$];
  bit  m_ovr, m_udr;

  uart_fifo dut (
    .clk(clk), .rst(rst), .en(en), .push_in(push_in), .pop_in(pop_in),
    .din(din), .dout(dout), .empty(empty), .full(full), .overrun(overrun),
    .underrun(underrun), .threshold(threshold), .thre_trigger(thre_trigger)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_dout;
    e_dout = (q.size() > 0) ? q[0] : 8'h00;
    chk({tag, ".dout"},     dout,         e_dout);
    chk({tag, ".empty"},    {7'd0, empty}, {7'd0, q.size() == 0});
    chk({tag, ".full"},     {7'd0, full},  {7'd0, q.size() == 16});
    chk({tag, ".overrun"},  {7'd0, overrun},  {7'd0, m_ovr});
    chk({tag, ".underrun"}, {7'd0, underrun}, {7'd0, m_udr});
    chk({tag, ".thre"},     {7'd0, thre_trigger},
        {7'd0, (threshold != 0) && (q.size() >= int'(threshold))});
  endtask

  // Apply one cycle of stimulus, advance the model from the spec rules, compare.
  task automatic step(input string tag, input bit p, input bit o, input bit e,
                      input logic [7:0] d);
    bit ovr_c, udr_c, acc_push, acc_pop;
    int n;
    push_in = p; pop_in = o; en = e; din = d;
    n        = q.size();
    acc_push = e && p && (n < 16 || o);
    acc_pop  = e && o && (n > 0);
    ovr_c    = e && p && (n == 16) && !o;
    udr_c    = e && o && (n == 0);
    @(posedge clk); #1;
    if (acc_pop)  void'(q.pop_front());
    if (acc_push) q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
    m_ovr = m_ovr | ovr_c;
    m_udr = m_udr | udr_c;
`else
    m_ovr = ovr_c;
    m_udr = udr_c;
`endif
    push_in = 1'b0; pop_in = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; push_in = 1'b0; pop_in = 1'b0; din = '0; threshold = 4'hA;
    m_ovr = 0; m_udr = 0;
    repeat (5) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst = 1'b1;

    // Fill: 20 pushes, last 4 overrun.
    for (int i = 0; i < 20; i++) step("fill", 1, 0, 1, 8'($urandom));
    // Drain: 20 pops, last 4 underrun.
    for (int i = 0; i < 20; i++) step("drain", 0, 1, 1, 8'h00);
    step("idle", 0, 0, 1, 8'h00);

    // Threshold change is combinational.
    for (int i = 0; i < 5; i++) step("pre_thr", 1, 0, 1, 8'($urandom));
    threshold = 4'd5; #1 check_all("thr_eq");
    threshold = 4'd6; #1 check_all("thr_above");
    threshold = 4'd0; #1 check_all("thr_zero");
    threshold = 4'hA;

    // Simultaneous push+pop when full.
    for (int i = 0; i < 11; i++) step("refill", 1, 0, 1, 8'($urandom));
    for (int i = 0; i < 3; i++)  step("full_pp", 1, 1, 1, 8'($urandom));
    for (int i = 0; i < 16; i++) step("drain2", 0, 1, 1, 8'h00);
    // Simultaneous push+pop when empty.
    step("empty_pp", 1, 1, 1, 8'h5C);
    step("after_epp", 0, 0, 1, 8'h00);

    // Disabled: requests ignored, state frozen.
    for (int i = 0; i < 3; i++) step("en0", 1, 1, 0, 8'hFF);

    // Async reset mid-fill at count 7.
    for (int i = 0; i < 6; i++) step("pre_rst", 1, 0, 1, 8'($urandom));
    #3 rst = 1'b0;
    #1;
    q.delete(); m_ovr = 0; m_udr = 0;
    check_all("async_rst");
    @(negedge clk) rst = 1'b1;

    // Random traffic with shifting push/pop bias.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      if (i % 20 == 0) threshold = 4'($urandom);
      step("rand", $urandom_range(99) < bias, $urandom_range(99) >= bias - 10,
           $urandom_range(9) != 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- 16-entry x 8-bit synchronous FIFO for the UART16550 TX/RX data paths.
- Provides full/empty status, overrun/underrun error pulses and a programmable fill-level trigger (thre_trigger) for interrupt generation.
- Instantiated once per direction by the UART top level.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two.
- AW, 4, pointer width, equal to log2(DEPTH); derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  global enable; when 0, push_in/pop_in are ignored and state holds.
- push_in  in  1  write request; din is stored at the tail.
- pop_in  in  1  read request; head entry is removed.
- din  in  WIDTH  write data.
- dout  out  WIDTH  head-of-FIFO data (show-ahead).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overrun  out  1  push attempted while full and not accepted.
- underrun  out  1  pop attempted while empty.
- threshold  in  AW  trigger level, 0..15.
- thre_trigger  out  1  fill level has reached threshold.

Behaviour:
- Reset (rst=0, async):
  - wr_ptr, rd_ptr and count (AW+1 bits) cleared.
  - overrun=0, underrun=0, thre_trigger=0, empty=1, full=0.
  - dout reads as 0.
  - Memory contents need not be cleared.
- All state updates on posedge clk, and only when en=1. en=0 freezes pointers and count, and clears the overrun/underrun pulses.
- Accepted push:
  - Condition: push_in & (!full | pop_in).
  - Writes mem[wr_ptr] <= din; wr_ptr increments, wrapping 15 -> 0.
- Accepted pop:
  - Condition: pop_in & !empty.
  - rd_ptr increments with wrap.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Both accepted: unchanged.
- Simultaneous push and pop:
  - When full: both accepted, count stays 16, no overrun.
  - When empty: push accepted, pop rejected, underrun pulses, count becomes 1.
- dout = mem[rd_ptr], combinational from the registered pointer, so data is valid in the same cycle empty=0. dout is 0 when empty.
- empty and full are decoded combinationally from the registered count.
- overrun and underrun are registered one-cycle pulses, asserted in the cycle after the offending edge.
  - overrun: push_in & full & !pop_in & en. Rejected data is discarded; FIFO contents are unchanged.
  - underrun: pop_in & empty & en. Pointers are unchanged.
- thre_trigger = (threshold != 0) & (count >= threshold). Combinational from the registered count; threshold changes take effect immediately.
- Reset asserted mid-operation: all data is discarded immediately and outputs return to their reset values.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined: overrun and underrun become sticky. Once set, each stays 1 until reset.
- Undefined: one-cycle pulses as described above.

Decomposition:
- Package uart_fifo_pkg holds:
  - localparams FIFO_WIDTH=8, FIFO_DEPTH=16, FIFO_AW=4.
  - typedef fifo_data_t (logic [7:0]).
  - typedef fifo_cnt_t (logic [4:0]).
- One sub-module, uart_fifo_mem: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port.
- Pointer, count and flag logic stays in uart_fifo.

Test Plan:
- Reset: hold rst=0 for 5 clocks -> empty=1, full=0, thre_trigger=0, overrun=0, underrun=0, dout=0.
- Fill with threshold=4'hA: push random bytes for 20 cycles, en=1.
  - thre_trigger rises after the 10th push.
  - full=1 after the 16th push.
  - overrun pulses for pushes 17-20.
  - Contents are the first 16 bytes.
- Drain: pop for 20 cycles.
  - dout shows the first 16 bytes in order.
  - thre_trigger falls when count drops to 9.
  - empty=1 after the 16th pop.
  - underrun pulses for pops 17-20.
- Simultaneous push+pop:
  - When full: count stays 16, dout advances, no overrun.
  - When empty: count becomes 1, underrun pulses once.
- en=0 with push_in=1, pop_in=1 for 3 cycles -> count, pointers and flags unchanged.
- Async reset mid-fill at count=7 -> empty=1 immediately, without waiting for a clock edge.
